// File: rtl/route_compute_stage.sv
// route_compute_stage: registered route-compute stage for one router input port.
// The destination of a HEAD flit is turned into an output port, and that port is
// locked for its virtual channel. BODY and TAIL flits reuse the locked port, and
// a TAIL releases the lock. Flits pass through one registered valid/ready stage.
// Optional build macro: RC_BOUNDS_CHECK_EN. When it is defined, a destination
// outside the MESH_X x MESH_Y mesh routes to LOCAL and raises err_bounds.
// out_port encoding: 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
//
// state  | meaning (per VC)
// FREE   | no packet in progress; route_reg holds the last route used
// LOCKED | HEAD seen; route_reg supplies the port for BODY/TAIL flits
module route_compute_stage #(
   parameter int X_CURRENT    = 0,
   parameter int Y_CURRENT    = 0,
   parameter int X_ADDR_W     = 2,
   parameter int Y_ADDR_W     = 2,
   parameter int NUM_VC       = 2,
   parameter int ROUTING_MODE = 0,
   parameter int MESH_X       = 4,
   parameter int MESH_Y       = 4,
   localparam int VC_W        = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [VC_W-1:0]     in_vc,
   input  logic [1:0]          in_type,
   input  logic [X_ADDR_W-1:0] in_x_des,
   input  logic [Y_ADDR_W-1:0] in_y_des,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [VC_W-1:0]     out_vc,
   output logic [1:0]          out_type,
   output logic [2:0]          out_port,
   output logic                err_protocol,
   output logic                err_bounds
);

   localparam logic [2:0] PORT_LOCAL = 3'd0;
   localparam logic [2:0] PORT_NORTH = 3'd1;
   localparam logic [2:0] PORT_EAST  = 3'd2;
   localparam logic [2:0] PORT_SOUTH = 3'd3;
   localparam logic [2:0] PORT_WEST  = 3'd4;

   localparam logic [1:0] T_HEAD     = 2'b00;
   localparam logic [1:0] T_BODY     = 2'b01;
   localparam logic [1:0] T_TAIL     = 2'b10;
   localparam logic [1:0] T_HEADTAIL = 2'b11;

   localparam logic [X_ADDR_W-1:0] X_CUR = X_ADDR_W'(X_CURRENT);
   localparam logic [Y_ADDR_W-1:0] Y_CUR = Y_ADDR_W'(Y_CURRENT);

   typedef enum logic {FREE = 1'b0, LOCKED = 1'b1} vc_state_t;

   vc_state_t   vc_state  [NUM_VC];
   logic [2:0]  route_reg [NUM_VC];

   logic            accept;
   logic            vc_bad;
   logic [VC_W-1:0] vc_idx;
   logic            head_any;
   logic            oob;
   logic [2:0]      head_route;
   logic [2:0]      nxt_port;
   logic            nxt_perr;

   // Pure compares, no subtraction, so unsigned destinations never wrap.
   function automatic logic [2:0] route_of(input logic [X_ADDR_W-1:0] x,
                                           input logic [Y_ADDR_W-1:0] y);
      logic [2:0] px;
      logic [2:0] py;
      px = (x < X_CUR) ? PORT_WEST  : (x > X_CUR) ? PORT_EAST  : PORT_LOCAL;
      py = (y < Y_CUR) ? PORT_NORTH : (y > Y_CUR) ? PORT_SOUTH : PORT_LOCAL;
      if (ROUTING_MODE == 0) return (px != PORT_LOCAL) ? px : py;
      else                   return (py != PORT_LOCAL) ? py : px;
   endfunction

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign vc_bad   = (int'(in_vc) >= NUM_VC);
   assign vc_idx   = vc_bad ? '0 : in_vc;
   assign head_any = (in_type == T_HEAD) || (in_type == T_HEADTAIL);

`ifdef RC_BOUNDS_CHECK_EN
   assign oob = head_any && ((int'(in_x_des) >= MESH_X) || (int'(in_y_des) >= MESH_Y));

   // The bounds error travels with its flit and lasts one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err_bounds <= 1'b0;
      else if (accept) err_bounds <= oob;
      else             err_bounds <= 1'b0;
   end
`else
   assign oob        = 1'b0;
   assign err_bounds = 1'b0;
`endif

   // Choose the outgoing port and detect flit-order violations for the incoming flit.
   always_comb begin
      head_route = route_of(in_x_des, in_y_des);
      if (oob) head_route = PORT_LOCAL;
      nxt_port = route_reg[vc_idx];
      nxt_perr = vc_bad;
      case (in_type)
         T_HEAD, T_HEADTAIL: begin
            nxt_port = head_route;
            if (vc_state[vc_idx] == LOCKED) nxt_perr = 1'b1;
         end
         default: begin
            if (vc_state[vc_idx] == FREE) nxt_perr = 1'b1;
         end
      endcase
   end

   // Lock state changes at acceptance, so a BODY accepted next cycle sees its HEAD's route.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_VC; i++) begin
            vc_state[i]  <= FREE;
            route_reg[i] <= PORT_LOCAL;
         end
      end else if (accept) begin
         if (in_type == T_HEAD) begin
            vc_state[vc_idx]  <= LOCKED;
            route_reg[vc_idx] <= head_route;
         end else if (in_type == T_TAIL && vc_state[vc_idx] == LOCKED) begin
            vc_state[vc_idx] <= FREE;
         end
      end
   end

   // Output register: loads on accept, holds while stalled, and empties once drained.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_vc       <= '0;
         out_type     <= 2'b00;
         out_port     <= PORT_LOCAL;
         err_protocol <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_vc       <= in_vc;
         out_type     <= in_type;
         out_port     <= nxt_port;
         err_protocol <= nxt_perr;
      end else begin
         err_protocol <= 1'b0;
         if (out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_route_compute_stage.sv
// Directed bench for route_compute_stage (X_CURRENT=2, Y_CURRENT=1, XY, 2 VCs),
// plus a second YX instance. Port codes: 0 LOCAL, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
module tb_route_compute_stage;

   localparam logic [2:0] LOCAL = 3'd0;
   localparam logic [2:0] NORTH = 3'd1;
   localparam logic [2:0] EAST  = 3'd2;
   localparam logic [2:0] SOUTH = 3'd3;
   localparam logic [2:0] WEST  = 3'd4;
   localparam logic [1:0] HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [0:0] in_vc, out_vc;
   logic [1:0] in_type, out_type;
   logic [2:0] in_x_des, in_y_des, out_port;
   logic       err_protocol, err_bounds;

   logic       b_in_valid, b_in_ready, b_out_valid;
   logic [0:0] b_in_vc, b_out_vc;
   logic [1:0] b_in_type, b_out_type;
   logic [2:0] b_in_x_des, b_in_y_des, b_out_port;
   logic       b_err_protocol, b_err_bounds;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   route_compute_stage #(.X_CURRENT(2), .Y_CURRENT(1), .X_ADDR_W(3), .Y_ADDR_W(3),
      .NUM_VC(2), .ROUTING_MODE(0), .MESH_X(4), .MESH_Y(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_vc(in_vc), .in_type(in_type), .in_x_des(in_x_des), .in_y_des(in_y_des),
      .out_valid(out_valid), .out_ready(out_ready), .out_vc(out_vc),
      .out_type(out_type), .out_port(out_port), .err_protocol(err_protocol),
      .err_bounds(err_bounds));

   route_compute_stage #(.X_CURRENT(2), .Y_CURRENT(1), .X_ADDR_W(3), .Y_ADDR_W(3),
      .NUM_VC(2), .ROUTING_MODE(1), .MESH_X(4), .MESH_Y(4)) dut_yx (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_vc(b_in_vc), .in_type(b_in_type), .in_x_des(b_in_x_des), .in_y_des(b_in_y_des),
      .out_valid(b_out_valid), .out_ready(1'b1), .out_vc(b_out_vc),
      .out_type(b_out_type), .out_port(b_out_port), .err_protocol(b_err_protocol),
      .err_bounds(b_err_bounds));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one input flit, then advance to just after the next rising edge.
   task automatic step(input logic v, input logic [0:0] vc, input logic [1:0] t,
                       input logic [2:0] x, input logic [2:0] y);
      in_valid = v; in_vc = vc; in_type = t; in_x_des = x; in_y_des = y;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [0:0] vc, input logic [1:0] t,
                          input logic [2:0] port, input logic perr);
      chk({tag, ".valid"}, 32'(out_valid), 32'(1'b1));
      chk({tag, ".vc"}, 32'(out_vc), 32'(vc));
      chk({tag, ".type"}, 32'(out_type), 32'(t));
      chk({tag, ".port"}, 32'(out_port), 32'(port));
      chk({tag, ".perr"}, 32'(err_protocol), 32'(perr));
   endtask

   initial begin
      rst_n = 1'b0; out_ready = 1'b1;
      in_valid = 0; in_vc = 0; in_type = 0; in_x_des = 0; in_y_des = 0;
      b_in_valid = 0; b_in_vc = 0; b_in_type = 0; b_in_x_des = 0; b_in_y_des = 0;
      #12;
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.vc", 32'(out_vc), 0);
      chk("rst.type", 32'(out_type), 0);
      chk("rst.port", 32'(out_port), 32'(LOCAL));
      chk("rst.perr", 32'(err_protocol), 0);
      chk("rst.berr", 32'(err_bounds), 0);
      chk("rst.in_ready", 32'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // HEADTAIL sweep; the YX instance routes (0,3) in the same cycle.
      b_in_valid = 1; b_in_vc = 0; b_in_type = HT; b_in_x_des = 3'd0; b_in_y_des = 3'd3;
      step(1, 0, HT, 3'd0, 3'd1); chk_out("ht_west", 0, HT, WEST, 0);
      chk("yx.valid", 32'(b_out_valid), 1);
      chk("yx.port", 32'(b_out_port), 32'(SOUTH));
      chk("yx.perr", 32'(b_err_protocol), 0);
      chk("yx.berr", 32'(b_err_bounds), 0);
      chk("yx.type", 32'(b_out_type), 32'(HT));
      chk("yx.vc", 32'(b_out_vc), 0);
      chk("yx.in_ready", 32'(b_in_ready), 1);
      b_in_valid = 0;
      step(1, 0, HT, 3'd3, 3'd0); chk_out("ht_east", 0, HT, EAST, 0);
      chk("yx.drain", 32'(b_out_valid), 0);
      step(1, 0, HT, 3'd2, 3'd0); chk_out("ht_north", 0, HT, NORTH, 0);
      step(1, 0, HT, 3'd2, 3'd3); chk_out("ht_south", 0, HT, SOUTH, 0);
      step(1, 0, HT, 3'd2, 3'd1); chk_out("ht_local", 0, HT, LOCAL, 0);
      chk("ht.berr", 32'(err_bounds), 0);

      // Full packet on VC0, then a stray BODY on the now-free VC.
      step(1, 0, HEAD, 3'd3, 3'd3); chk_out("pk_head", 0, HEAD, EAST, 0);
      step(1, 0, BODY, 3'd0, 3'd0); chk_out("pk_body1", 0, BODY, EAST, 0);
      step(1, 0, BODY, 3'd0, 3'd0); chk_out("pk_body2", 0, BODY, EAST, 0);
      step(1, 0, TAIL, 3'd0, 3'd0); chk_out("pk_tail", 0, TAIL, EAST, 0);
      step(1, 0, BODY, 3'd0, 3'd0); chk_out("stray_body", 0, BODY, EAST, 1);
      step(0, 0, BODY, 3'd0, 3'd0);
      chk("idle.valid", 32'(out_valid), 0);
      chk("idle.perr", 32'(err_protocol), 0);

      // HEAD on a locked VC overwrites the route; HEADTAIL on locked leaves it.
      step(1, 0, HEAD, 3'd3, 3'd3); chk_out("rl_head", 0, HEAD, EAST, 0);
      step(1, 0, HT, 3'd2, 3'd3); chk_out("rl_ht", 0, HT, SOUTH, 1);
      step(1, 0, BODY, 3'd0, 3'd0); chk_out("rl_body", 0, BODY, EAST, 0);
      step(1, 0, HEAD, 3'd0, 3'd1); chk_out("rl_head2", 0, HEAD, WEST, 1);
      step(1, 0, BODY, 3'd0, 3'd0); chk_out("rl_body2", 0, BODY, WEST, 0);
      step(1, 0, TAIL, 3'd0, 3'd0); chk_out("rl_tail", 0, TAIL, WEST, 0);

      // Interleaved VCs keep independent locks.
      step(1, 0, HEAD, 3'd0, 3'd0); chk_out("il_h0", 0, HEAD, WEST, 0);
      step(1, 1, HEAD, 3'd2, 3'd3); chk_out("il_h1", 1, HEAD, SOUTH, 0);
      step(1, 0, BODY, 3'd7, 3'd7); chk_out("il_b0", 0, BODY, WEST, 0);
      step(1, 1, BODY, 3'd7, 3'd7); chk_out("il_b1", 1, BODY, SOUTH, 0);
      step(1, 0, TAIL, 3'd0, 3'd0); chk_out("il_t0", 0, TAIL, WEST, 0);
      step(1, 1, TAIL, 3'd0, 3'd0); chk_out("il_t1", 1, TAIL, SOUTH, 0);

      // Back-pressure: three stalled cycles, then the waiting flit follows without a bubble.
      step(1, 0, HT, 3'd2, 3'd0); chk_out("bp_first", 0, HT, NORTH, 0);
      out_ready = 1'b0;
      in_valid = 1; in_vc = 1; in_type = HT; in_x_des = 3'd0; in_y_des = 3'd1;
      #1;
      chk("bp.in_ready", 32'(in_ready), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp.stall_valid", 32'(out_valid), 1);
         chk("bp.stall_port", 32'(out_port), 32'(NORTH));
         chk("bp.stall_vc", 32'(out_vc), 0);
         chk("bp.stall_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk_out("bp_next", 1, HT, WEST, 0);

      // Reset mid-packet clears the output at once and frees the lock.
      step(1, 0, HEAD, 3'd3, 3'd3); chk_out("mr_head", 0, HEAD, EAST, 0);
      in_valid = 1; in_vc = 0; in_type = BODY;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr.valid", 32'(out_valid), 0);
      chk("mr.port", 32'(out_port), 32'(LOCAL));
      in_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 0, BODY, 3'd0, 3'd0); chk_out("mr_body", 0, BODY, LOCAL, 1);

      // Out-of-mesh destination.
`ifdef RC_BOUNDS_CHECK_EN
      step(1, 1, HEAD, 3'd5, 3'd1); chk_out("bd_head", 1, HEAD, LOCAL, 0);
      chk("bd.berr", 32'(err_bounds), 1);
      step(1, 1, TAIL, 3'd0, 3'd0); chk_out("bd_tail", 1, TAIL, LOCAL, 0);
`else
      step(1, 1, HEAD, 3'd5, 3'd1); chk_out("bd_head", 1, HEAD, EAST, 0);
      chk("bd.berr", 32'(err_bounds), 0);
      step(1, 1, TAIL, 3'd0, 3'd0); chk_out("bd_tail", 1, TAIL, EAST, 0);
`endif
      chk("bd.berr_clear", 32'(err_bounds), 0);
      step(0, 0, HEAD, 3'd0, 3'd0);
      chk("end.valid", 32'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
